// File: rtl/controlador_memoria.sv
// Main-memory controller behind the data cache: owns the byte array,
// serves two-beat block refills and drains a FIFO of write-through stores.
module controlador_memoria #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 3,
  parameter int WB_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refill_req,
  input  logic [63:0] refill_addr,
  output logic        refill_ready,
  output logic        refill_valid,
  output logic        refill_beat,
  output logic [63:0] refill_data,
  input  logic        wr_valid,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  output logic        wr_ready,
  output logic        busy
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT0,
    BEAT1
  } state_t;

  // Contents survive reset; zero only at power-up.
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

  logic [AW-1:0] wb_addr [WB_DEPTH];
  logic [63:0]   wb_data [WB_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   wb_count;
  logic          enq;
  logic          deq;

  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic [AW-1:0] base;
  logic [AW-1:0] nxt_base;
  logic          nxt_valid;
  logic          nxt_beat;
  logic [63:0]   nxt_data;
  logic [63:0]   rd_lo;
  logic [63:0]   rd_hi;
  logic [AW-1:0] drain_addr;
  logic [63:0]   drain_data;

  logic unused;
  assign unused = ^{refill_addr[63:AW], refill_addr[3:0], wr_addr[63:AW]};

  assign refill_ready = (state == IDLE) && (wb_count == '0);
  assign wr_ready     = (wb_count != (PW+1)'(WB_DEPTH));
  assign busy         = (state != IDLE) || (wb_count != '0);

  assign enq = wr_valid && wr_ready;
  assign deq = (state == IDLE) && (wb_count != '0);

  assign drain_addr = wb_addr[rd_ptr];
  assign drain_data = wb_data[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({enq, deq})
        2'b10:   wb_count <= wb_count + (PW+1)'(1);
        2'b01:   wb_count <= wb_count - (PW+1)'(1);
        default: wb_count <= wb_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr[wr_ptr] <= wr_addr[AW-1:0];
      wb_data[wr_ptr] <= wr_data;
    end
  end

  // Byte address wraps at the top of memory.
  always_ff @(posedge clk) begin
    if (deq) begin
      for (int k = 0; k < 8; k++) begin
        mem[drain_addr + AW'(k)] <= drain_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_lo = '0;
    rd_hi = '0;
    for (int k = 0; k < 8; k++) begin
      rd_lo[8*k +: 8] = mem[base + AW'(k)];
      rd_hi[8*k +: 8] = mem[base + AW'(k + 8)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      base         <= '0;
      refill_valid <= 1'b0;
      refill_beat  <= 1'b0;
      refill_data  <= '0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      base         <= nxt_base;
      refill_valid <= nxt_valid;
      refill_beat  <= nxt_beat;
      refill_data  <= nxt_data;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_base  = base;
    nxt_valid = refill_valid;
    nxt_beat  = refill_beat;
    nxt_data  = refill_data;
    unique case (state)
      IDLE: begin
        if (refill_req && refill_ready) begin
          nxt_base  = {refill_addr[AW-1:4], 4'b0000};
          nxt_cnt   = CW'(LATENCY - 1);
          nxt_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          nxt_state = BEAT0;
          nxt_valid = 1'b1;
          nxt_beat  = 1'b0;
          nxt_data  = rd_lo;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      BEAT0: begin
        nxt_state = BEAT1;
        nxt_valid = 1'b1;
        nxt_beat  = 1'b1;
        nxt_data  = rd_hi;
      end
      BEAT1: begin
        nxt_state = IDLE;
        nxt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_controlador_memoria.sv
// Directed bench for controlador_memoria: refill timing, write buffer
// ordering, wrap-around, reset abort and same-edge write/refill ordering.
module tb_controlador_memoria;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refill_req = 1'b0;
  logic [63:0] refill_addr = '0;
  logic        refill_ready;
  logic        refill_valid;
  logic        refill_beat;
  logic [63:0] refill_data;
  logic        wr_valid = 1'b0;
  logic [63:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        wr_ready;
  logic        busy;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] D48 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] A1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] A2  = 64'h2A2B_2C2D_2122_2324;
  localparam logic [63:0] A3  = 64'h3A3B_3C3D_3132_3334;
  localparam logic [63:0] A4  = 64'h4040_4141_4242_4343;
  localparam logic [63:0] A5  = 64'h5566_7788_99AA_BBCC;
  localparam logic [63:0] WRP = 64'hAABB_CCDD_EEFF_0011;
  localparam logic [63:0] DZ  = 64'hDEAD_BEEF_0BAD_F00D;

  always #5 clk = ~clk;

  controlador_memoria dut (
    .clk          (clk),
    .reset        (rst),
    .refill_req   (refill_req),
    .refill_addr  (refill_addr),
    .refill_ready (refill_ready),
    .refill_valid (refill_valid),
    .refill_beat  (refill_beat),
    .refill_data  (refill_data),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!refill_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, {63'd0, refill_ready}, 64'd1);
  endtask

  task automatic do_refill(input string tag, input logic [63:0] a,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic wv = 1'b0,
                           input logic [63:0] wa = '0,
                           input logic [63:0] wd = '0);
    wait_ready(tag);
    refill_req  = 1'b1;
    refill_addr = a;
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    step();
    refill_req = 1'b0;
    wr_valid   = 1'b0;
    chk({tag, "_acc_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_acc_rdy"}, {63'd0, refill_ready}, 64'd0);
    step();
    step();
    chk({tag, "_lat_v"}, {63'd0, refill_valid}, 64'd0);
    step();
    chk({tag, "_b0_v"}, {63'd0, refill_valid}, 64'd1);
    chk({tag, "_b0_beat"}, {63'd0, refill_beat}, 64'd0);
    chk({tag, "_b0_data"}, refill_data, e0);
    step();
    chk({tag, "_b1_v"}, {63'd0, refill_valid}, 64'd1);
    chk({tag, "_b1_beat"}, {63'd0, refill_beat}, 64'd1);
    chk({tag, "_b1_data"}, refill_data, e1);
    step();
    chk({tag, "_end_v"}, {63'd0, refill_valid}, 64'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {63'd0, refill_valid}, 64'd0);
    chk("rst_beat", {63'd0, refill_beat}, 64'd0);
    chk("rst_data", refill_data, 64'd0);
    chk("rst_rdy", {63'd0, refill_ready}, 64'd1);
    chk("rst_wrdy", {63'd0, wr_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    // Zero memory refill; ready returns two cycles after beat0.
    do_refill("r40", 64'h40, 64'd0, 64'd0);
    chk("r40_rdy_end", {63'd0, refill_ready}, 64'd1);
    chk("r40_busy_end", {63'd0, busy}, 64'd0);

    // Buffered store blocks refill until drained.
    wr_valid = 1'b1;
    wr_addr  = 64'h48;
    wr_data  = D48;
    step();
    wr_valid = 1'b0;
    chk("st48_rdy", {63'd0, refill_ready}, 64'd0);
    chk("st48_busy", {63'd0, busy}, 64'd1);
    do_refill("r40b", 64'h40, 64'd0, D48);

    // Five stores around an in-flight refill; fifth waits for a drain.
    wait_ready("wb");
    refill_req  = 1'b1;
    refill_addr = 64'h100;
    wr_valid    = 1'b1;
    wr_addr     = 64'h200;
    wr_data     = A1;
    step();
    refill_req = 1'b0;
    wr_addr    = 64'h208;
    wr_data    = A2;
    step();
    wr_addr = 64'h204;
    wr_data = A3;
    step();
    wr_addr = 64'h210;
    wr_data = A4;
    step();
    chk("wb_b0_v", {63'd0, refill_valid}, 64'd1);
    chk("wb_b0_data", refill_data, 64'd0);
    wr_addr = 64'h200;
    wr_data = A5;
    chk("wb_full0", {63'd0, wr_ready}, 64'd0);
    step();
    chk("wb_b1_beat", {63'd0, refill_beat}, 64'd1);
    chk("wb_full1", {63'd0, wr_ready}, 64'd0);
    step();
    chk("wb_idle_v", {63'd0, refill_valid}, 64'd0);
    chk("wb_full2", {63'd0, wr_ready}, 64'd0);
    step();
    chk("wb_freed", {63'd0, wr_ready}, 64'd1);
    step();
    wr_valid = 1'b0;
    do_refill("wb200", 64'h200, A5, 64'h2A2B_2C2D_3A3B_3C3D);
    do_refill("wb210", 64'h210, A4, 64'd0);

    // Store straddling the top of memory wraps to address 0.
    wr_valid = 1'b1;
    wr_addr  = 64'h3FC;
    wr_data  = WRP;
    step();
    wr_valid = 1'b0;
    do_refill("wrap0", 64'h0, 64'h0000_0000_AABB_CCDD, 64'd0);
    do_refill("wrap3f0", 64'hFFFF_0000_0000_03F0, 64'd0,
              64'hEEFF_0011_0000_0000);

    // Reset during WAIT with two buffered stores.
    wait_ready("rw");
    refill_req  = 1'b1;
    refill_addr = 64'h300;
    wr_valid    = 1'b1;
    wr_addr     = 64'h300;
    wr_data     = A1;
    step();
    refill_req = 1'b0;
    wr_addr    = 64'h308;
    wr_data    = A2;
    step();
    wr_valid = 1'b0;
    chk("rw_busy_pre", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_valid", {63'd0, refill_valid}, 64'd0);
    chk("rw_data", refill_data, 64'd0);
    chk("rw_busy", {63'd0, busy}, 64'd0);
    chk("rw_rdy", {63'd0, refill_ready}, 64'd1);
    chk("rw_wrdy", {63'd0, wr_ready}, 64'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rw_nobeat", {63'd0, refill_valid}, 64'd0);
    end
    do_refill("rw300", 64'h300, 64'd0, 64'd0);

    // Same-edge store is younger than the refill.
    do_refill("se_old", 64'h340, 64'd0, 64'd0, 1'b1, 64'h340, DZ);
    do_refill("se_new", 64'h340, DZ, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/controlador_memoria.md
Name: controlador_memoria

Overview:
- Main-memory controller directly downstream of the data cache.
- Owns the 1024-byte main memory array and serves 16-byte block refills on cache read misses. Each refill is returned as two 64-bit beats after a fixed access latency.
- Absorbs write-through stores in a small FIFO write buffer and drains them into memory in the background.
- Refills are ordered behind all earlier buffered writes, so a refill never returns stale data.

Parameters:
- MEM_BYTES, 1024, main memory size in bytes; byte address = addr mod MEM_BYTES.
- LATENCY, 3, cycles from refill acceptance to first beat; legal range ≥1.
- WB_DEPTH, 4, write buffer entries; power of two.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- refill_req  in  1  cache requests a block refill
- refill_addr  in  64  miss address; bits [3:0] ignored (block aligned)
- refill_ready  out  1  refill can be accepted this cycle
- refill_valid  out  1  refill_data holds a valid beat
- refill_beat  out  1  0 = bytes 0..7 of block, 1 = bytes 8..15
- refill_data  out  64  beat data, little-endian (byte 0 in [7:0])
- wr_valid  in  1  write-through store request
- wr_addr  in  64  store byte address (unaligned allowed)
- wr_data  in  64  store data, little-endian
- wr_ready  out  1  write buffer can accept a store
- busy  out  1  refill in progress or write buffer non-empty

Behaviour:
- Reset (async, immediate):
  - refill_valid=0, refill_beat=0, refill_data=0, state=IDLE, latency counter=0.
  - Write buffer flushed (count=0, pointers=0); pending writes are discarded.
  - Memory contents are retained. Memory is zero at time 0 via initialisation only, not via reset.
  - Reset mid-refill aborts the refill; no beat is issued afterwards.
- Combinational outputs:
  - refill_ready = (state==IDLE) && (wb_count==0).
  - wr_ready = (wb_count != WB_DEPTH).
  - busy = (state!=IDLE) || (wb_count!=0).
  - All other outputs are registered.
- Write buffer:
  - Enqueue on an edge with wr_valid && wr_ready; stores {wr_addr, wr_data}.
  - When full, wr_ready=0 even if a dequeue occurs the same cycle (no bypass).
  - Drain: in state IDLE with wb_count>0, one entry per cycle. Memory bytes (addr+k) mod MEM_BYTES ← wr_data[8k+7:8k], k=0..7, and the entry is dequeued. Wrap-around of the byte address at MEM_BYTES-1 → 0 is required.
  - Simultaneous enqueue and dequeue keeps the count unchanged.
  - Entries drain in FIFO order; a later write to the same byte wins.
- Refill FSM states: IDLE → WAIT → BEAT0 → BEAT1 → IDLE.
  - IDLE: on an edge with refill_req && refill_ready, latch base = refill_addr mod MEM_BYTES with bits [3:0] cleared. Load counter = LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter each edge. When the counter is 0, go to BEAT0 and register refill_valid=1, refill_beat=0, refill_data = mem[base+7 .. base+0].
  - BEAT0 → BEAT1: refill_valid=1, refill_beat=1, refill_data = mem[base+15 .. base+8].
  - BEAT1 → IDLE: refill_valid=0.
  - No back-pressure on beats; the cache must consume both.
- Timing: with acceptance at edge t0, beat0 is visible after edge t0+LATENCY and beat1 after edge t0+LATENCY+1. refill_ready can be 1 again after edge t0+LATENCY+2.
- refill_req while refill_ready=0 is ignored; the cache must hold the request. Address bits above the memory range are ignored (mod MEM_BYTES).
- Simultaneous events: a wr_valid arriving on the same edge that a refill is accepted is treated as younger than the refill. It is enqueued, the refill returns pre-write data, and the write drains after the refill completes.
- No store is drained while state != IDLE.

Test Plan:
- Reset then refill_req, refill_addr=0x40 (memory zero) → accepted at edge 0; refill_valid=1, beat0 data 0 after edge 3; beat1 data 0 after edge 4; refill_ready=1 after edge 5.
- Store wr_addr=0x48, wr_data=0x1122334455667788, then refill 0x40 → refill_ready held 0 until drained. Beat0=0, beat1=0x1122334455667788.
- Five back-to-back stores while a refill is in WAIT → wr_ready=0 on the 5th; 5th accepted after BEAT1 once a drain frees an entry. Memory ends with all 5 in order.
- Store at wr_addr=0x3FC with 0xAABBCCDDEEFF0011 → bytes 0x3FC..0x3FF=11,00,FF,EE and 0x000..0x003=DD,CC,BB,AA. Refill 0x000 beat0 low word = 0xAABBCCDD.
- Assert reset during WAIT with 2 writes buffered → outputs immediately zero, busy=0, no beat issued, the buffered writes absent from memory. A new refill works normally.
- Refill accepted on the same edge as wr_valid to the same block → returns old data. A subsequent refill returns new data.
